byte_serializer: RTL and testbench

BYTE_SERIALIZER -- requirements
Module: byte_serializer

---
 rtl/byte_serializer.sv | 104 ++++++++++
 tb/tb_byte_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/byte_serializer.sv
// Word-to-bitstream serializer: one active shift register plus one pending
// holding register, so back-to-back words stream with no idle gap.
module byte_serializer #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept;
    logic last_bit;
    logic [DATA_W-1:0] shifted;

    // Handshake: a word transfers at a rising edge where in_valid and in_ready
    // are both high; in_ready depends only on the holding slot and reset.
    assign in_ready = !hold_full_q && !reset;
    assign accept   = in_valid && in_ready;
    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

    assign shifted = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0}
                               : {1'b0, shift_q[DATA_W-1:1]};

    assign ser_valid = (state_q == ST_SHIFT);
    assign ser_bit   = ser_valid & (MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0]);
    assign ser_last  = last_bit;
    assign busy      = (state_q == ST_SHIFT) || hold_full_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                if (!last_bit) begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (accept) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Pending word takes over the shifter on the very next cycle.
                    shift_d     = hold_q;
                    hold_d      = '0;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    shift_d = in_data;
                    cnt_d   = '0;
                end else begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: an MSB-first and an LSB-first instance, each
// checked bit by bit against a queue of expected {last, bit} pairs.
module tb_byte_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] in_data_a, in_data_b;
    logic       in_valid_a, in_valid_b;
    logic       in_ready_a, in_ready_b;
    logic       ser_bit_a, ser_bit_b;
    logic       ser_valid_a, ser_valid_b;
    logic       ser_last_a, ser_last_b;
    logic       busy_a, busy_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] exp_q_a[$];
    logic [1:0] exp_q_b[$];
    logic [1:0] e_a, e_b;

    byte_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .ser_bit(ser_bit_a), .ser_valid(ser_valid_a),
        .ser_last(ser_last_a), .busy(busy_a)
    );

    byte_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .ser_bit(ser_bit_b), .ser_valid(ser_valid_b),
        .ser_last(ser_last_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input int sel, input logic [7:0] w);
        logic [1:0] ent;
        for (int i = 0; i < 8; i++) begin
            ent[0] = (sel == 0) ? w[7-i] : w[i];
            ent[1] = (i == 7);
            if (sel == 0) exp_q_a.push_back(ent);
            else          exp_q_b.push_back(ent);
        end
    endtask

    // Presents w from the next falling edge; returns just after the accepting
    // rising edge with in_valid still high. waited counts not-ready cycles.
    task automatic send(input int sel, input logic [7:0] w, output int waited);
        waited = 0;
        @(negedge clk);
        if (sel == 0) begin in_valid_a = 1'b1; in_data_a = w; end
        else          begin in_valid_b = 1'b1; in_data_b = w; end
        while (((sel == 0) ? in_ready_a : in_ready_b) !== 1'b1) begin
            if (waited >= 64) begin
                check("send_timeout", 32'd1, 32'd0);
                in_valid_a = 1'b0;
                in_valid_b = 1'b0;
                return;
            end
            waited++;
            @(negedge clk);
        end
        @(posedge clk);
        push_word(sel, w);
    endtask

    // Expects exactly n more ser_valid cycles then an idle, non-busy cycle.
    task automatic expect_run(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                in_valid_a = 1'b0;
                in_valid_b = 1'b0;
                in_data_a  = 8'($urandom_range(0, 255));
                in_data_b  = 8'($urandom_range(0, 255));
            end
            check("run_valid", (sel == 0) ? ser_valid_a : ser_valid_b, 1);
            check("run_busy",  (sel == 0) ? busy_a : busy_b, 1);
        end
        @(negedge clk);
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        check("run_end_valid", (sel == 0) ? ser_valid_a : ser_valid_b, 0);
        check("run_end_busy",  (sel == 0) ? busy_a : busy_b, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (reset) exp_q_a.delete();
        else if (ser_valid_a) begin
            if (exp_q_a.size() == 0) check("a_extra_bit", 32'd1, 32'd0);
            else begin
                e_a = exp_q_a.pop_front();
                check("a_last_bit", {ser_last_a, ser_bit_a}, e_a);
            end
        end else check("a_idle_zero", {ser_last_a, ser_bit_a}, 0);
    end

    always @(posedge clk) begin
        #1;
        if (reset) exp_q_b.delete();
        else if (ser_valid_b) begin
            if (exp_q_b.size() == 0) check("b_extra_bit", 32'd1, 32'd0);
            else begin
                e_b = exp_q_b.pop_front();
                check("b_last_bit", {ser_last_b, ser_bit_b}, e_b);
            end
        end else check("b_idle_zero", {ser_last_b, ser_bit_b}, 0);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        reset      = 1'b1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_data_a  = '0;
        in_data_b  = '0;
        repeat (3) @(negedge clk);
        check("rst_valid_a", ser_valid_a, 0);
        check("rst_busy_a",  busy_a, 0);
        check("rst_ready_a", in_ready_a, 0);
        check("rst_bit_a",   {ser_last_a, ser_bit_a}, 0);
        check("rst_busy_b",  busy_b, 0);
        check("rst_ready_b", in_ready_b, 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready_a", in_ready_a, 1);

        // Single word, MSB first
        send(0, 8'hB0, w);
        check("b0_wait", w, 0);
        expect_run(0, 8);

        // Back-to-back with a third word stalled on the full holding register
        send(0, 8'hB5, w);
        send(0, 8'h0B, w);
        check("second_accept_wait", w, 0);
        send(0, 8'hFF, w);
        check("ff_stall_cycles", w, 7);
        expect_run(0, 15);

        // LSB first
        send(1, 8'h0D, w);
        check("lsb_wait", w, 0);
        expect_run(1, 8);

        // Reset mid-word with a pending word
        send(0, 8'hB5, w);
        send(0, 8'h0B, w);
        @(negedge clk);
        in_valid_a = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_valid", ser_valid_a, 0);
        check("midrst_busy",  busy_a, 0);
        check("midrst_ready", in_ready_a, 0);
        reset = 1'b0;
        #1;
        check("midrst_ready_after", in_ready_a, 1);
        send(0, 8'h80, w);
        check("after_rst_wait", w, 0);
        expect_run(0, 8);

        // in_valid during reset is ignored
        @(negedge clk);
        reset      = 1'b1;
        in_valid_a = 1'b1;
        in_data_a  = 8'hAA;
        in_valid_b = 1'b1;
        in_data_b  = 8'hAA;
        repeat (3) @(negedge clk);
        reset      = 1'b0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("rst_valid_ignored_a", {busy_a, ser_valid_a}, 0);
            check("rst_valid_ignored_b", {busy_b, ser_valid_b}, 0);
        end

        // Random words streamed back to back on both instances
        for (int k = 0; k < 6; k++) send(0, 8'($urandom_range(0, 255)), w);
        @(negedge clk);
        in_valid_a = 1'b0;
        for (int k = 0; k < 4; k++) send(1, 8'($urandom_range(0, 255)), w);
        @(negedge clk);
        in_valid_b = 1'b0;
        repeat (40) @(negedge clk);
        check("a_queue_drained", exp_q_a.size(), 0);
        check("b_queue_drained", exp_q_b.size(), 0);
        check("a_final_busy", busy_a, 0);
        check("b_final_busy", busy_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
